// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory port between instruction fetch
// and the data stage, with grant/wait/complete sequencing and hazard stalls.
module mem_port_arbiter #(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_fetch,
  output logic        stall_pipe
);

  localparam int unsigned CNT_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   starve_cnt;
  logic [CNT_W-1:0]   starve_nxt;
  logic               bubble;
  logic               if_elig;
  logic               dm_elig;
  logic               gnt_if;
  logic               gnt_dm;
  logic               complete;

  // The done cycle is a full bubble: a stale request of the finishing
  // requester must not be re-granted, and no other grant is issued either.
  assign bubble  = if_done | dm_done;
  assign if_elig = if_req & ~bubble;
  assign dm_elig = dm_req & ~bubble;

  // Structural-hazard stalls: pending until the done pulse arrives.
  assign stall_fetch = if_req & ~if_done;
  assign stall_pipe  = dm_req & ~dm_done;

  // Next-state, grant decision and fairness counter update.
  always_comb begin
    state_nxt  = state;
    gnt_if     = 1'b0;
    gnt_dm     = 1'b0;
    complete   = 1'b0;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (dm_elig && (!if_elig || (starve_cnt < CNT_W'(FAIR_LIMIT)))) begin
          gnt_dm    = 1'b1;
          state_nxt = GNT_DM;
        end else if (if_elig) begin
          gnt_if    = 1'b1;
          state_nxt = GNT_IF;
        end
      end
      GNT_IF, GNT_DM: begin
        if (mem_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!if_req || gnt_if) begin
      starve_nxt = '0;
    end else if (gnt_dm && (starve_cnt < CNT_W'(FAIR_LIMIT))) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // State register and fairness counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Memory-side request registers, captured at grant and held until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (gnt_if) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (gnt_dm) begin
      mem_req   <= 1'b1;
      mem_we    <= dm_we;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
      mem_wstrb <= dm_we ? dm_wstrb : 4'b0000;
    end else if (complete) begin
      mem_req   <= 1'b0;
    end
  end

  // Completion pulses and read-data return to the winning requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_done <= complete & (state == GNT_IF);
      dm_done <= complete & (state == GNT_DM);
      if (complete && (state == GNT_IF)) begin
        if_rdata <= mem_rdata;
      end
      if (complete && (state == GNT_DM) && !mem_we) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

`ifndef SYNTHESIS
  logic if_hold;
  logic dm_hold;

  // Tracks requests that must still be held by their requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_hold <= 1'b0;
      dm_hold <= 1'b0;
    end else begin
      if_hold <= if_req & ~if_done;
      dm_hold <= dm_req & ~dm_done;
    end
  end

  a_if_req_held: assert property (@(posedge clk) disable iff (rst)
    !(if_hold && !if_req && !if_done));
  a_dm_req_held: assert property (@(posedge clk) disable iff (rst)
    !(dm_hold && !dm_req && !dm_done));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single accesses plus
// hand sequences for arbitration order, fairness, wait states and reset abort.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_fetch;
  logic        stall_pipe;

  mem_port_arbiter #(.FAIR_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_fetch(stall_fetch), .stall_pipe(stall_pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] exp;
  } rq_t;

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  int          n_chk;
  int          n_fail;
  int          cyc;
  int          wait_cfg;
  int          wait_left;
  logic        in_access;
  logic        noise_ready;
  acc_t        cap;
  rq_t         if_q[$];
  rq_t         dm_q[$];
  exp_t        sb_if[$];
  exp_t        sb_dm[$];
  bit          kind_q[$];
  bit          order_q[$];
  bit [31:0]   mem_img [bit [31:0]];
  vec_t        vecs[8];
  bit          exp_ord[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : 32'h0;
  endfunction

  // One clock: monitor completions, model the memory, update requesters, check stalls.
  task automatic step();
    exp_t        e;
    rq_t         r;
    logic [31:0] w;
    bit          k;
    @(posedge clk);
    #1;
    cyc++;
    chk("done_exclusive", 32'(if_done & dm_done), 32'h0);
    if (if_done) begin
      if (sb_if.size() == 0) fail_now("if_done_unexpected");
      else begin
        e = sb_if.pop_front();
        chk("if_rdata", if_rdata, e.rdata);
        if (e.due >= 0) chk("if_latency", 32'(cyc), 32'(e.due));
        order_q.push_back(1'b0);
      end
      if (kind_q.size() == 0) fail_now("if_done_without_access");
      else begin
        k = kind_q.pop_front();
        chk("if_done_kind", 32'(k), 32'h0);
      end
    end
    if (dm_done) begin
      if (sb_dm.size() == 0) fail_now("dm_done_unexpected");
      else begin
        e = sb_dm.pop_front();
        chk("dm_rdata", dm_rdata, e.rdata);
        if (e.due >= 0) chk("dm_latency", 32'(cyc), 32'(e.due));
        order_q.push_back(1'b1);
      end
      if (kind_q.size() == 0) fail_now("dm_done_without_access");
      else begin
        k = kind_q.pop_front();
        chk("dm_done_kind", 32'(k), 32'h1);
      end
    end
    if (if_done || dm_done) chk("bubble_mem_req", 32'(mem_req), 32'h0);

    mem_ready = 1'b0;
    if (mem_req) begin
      if (!in_access) begin
        in_access = 1'b1;
        wait_left = wait_cfg;
        cap = '{mem_we, mem_addr, mem_wdata, mem_wstrb};
        if (if_req && !mem_we && (mem_addr == if_addr)) begin
          kind_q.push_back(1'b0);
          chk("fetch_wdata", mem_wdata, 32'h0);
          chk("fetch_wstrb", 32'(mem_wstrb), 32'h0);
        end else begin
          kind_q.push_back(1'b1);
          chk("dm_req_held", 32'(dm_req), 32'h1);
          chk("dm_addr", mem_addr, dm_addr);
          chk("dm_we", 32'(mem_we), 32'(dm_we));
          chk("dm_wstrb", 32'(mem_wstrb), dm_we ? 32'(dm_wstrb) : 32'h0);
          if (dm_we) chk("dm_wdata", mem_wdata, dm_wdata);
        end
      end else begin
        chk("stable_addr", mem_addr, cap.addr);
        chk("stable_we", 32'(mem_we), 32'(cap.we));
        chk("stable_wdata", mem_wdata, cap.wdata);
        chk("stable_wstrb", 32'(mem_wstrb), 32'(cap.wstrb));
      end
      if (wait_left == 0) begin
        mem_ready = 1'b1;
        mem_rdata = rd_mem(mem_addr);
        if (mem_we) begin
          w = rd_mem(mem_addr);
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_img[mem_addr] = w;
        end
        in_access = 1'b0;
      end else begin
        wait_left--;
        mem_rdata = $urandom;
      end
    end else begin
      if (in_access) begin
        fail_now("mem_req_dropped_early");
        in_access = 1'b0;
      end
      mem_ready = noise_ready;
      mem_rdata = 32'hBAD0BAD0;
    end

    if (!if_req || if_done) begin
      if (if_q.size() > 0) begin
        r = if_q.pop_front();
        if_req  = 1'b1;
        if_addr = r.addr;
        sb_if.push_back('{r.exp, (r.lat >= 0) ? cyc + r.lat : -1});
      end else begin
        if_req = 1'b0;
      end
    end
    if (!dm_req || dm_done) begin
      if (dm_q.size() > 0) begin
        r = dm_q.pop_front();
        dm_req   = 1'b1;
        dm_we    = r.we;
        dm_addr  = r.addr;
        dm_wdata = r.wdata;
        dm_wstrb = r.wstrb;
        sb_dm.push_back('{r.exp, (r.lat >= 0) ? cyc + r.lat : -1});
      end else begin
        dm_req = 1'b0;
      end
    end
    #1;
    chk("stall_fetch", 32'(stall_fetch), 32'(if_req & ~if_done));
    chk("stall_pipe", 32'(stall_pipe), 32'(dm_req & ~dm_done));
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((if_q.size() > 0 || dm_q.size() > 0 || sb_if.size() > 0 || sb_dm.size() > 0 ||
            if_req || dm_req || in_access) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail_now("timeout_waiting_for_idle");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    chk({tag, "_if_done"}, 32'(if_done), 32'h0);
    chk({tag, "_dm_done"}, 32'(dm_done), 32'h0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    wait_cfg = 0; wait_left = 0; in_access = 1'b0; noise_ready = 1'b0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    mem_img[32'h100]  = 32'h00000013;
    mem_img[32'h104]  = 32'h00A00093;
    mem_img[32'h2000] = 32'h12345678;
    mem_img[32'h40]   = 32'hFFFFFFFF;

    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'b0000, 1, 32'h00000013};
    vecs[1] = '{1'b1, 1'b0, 32'h2000, 32'h0,        4'b0000, 0, 32'h12345678};
    vecs[2] = '{1'b1, 1'b1, 32'h40,   32'hDEADBEEF, 4'b0011, 0, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h40,   32'h0,        4'b0000, 2, 32'hFFFFBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h104,  32'h0,        4'b0000, 3, 32'h00A00093};
    vecs[5] = '{1'b1, 1'b0, 32'h2000, 32'h55555555, 4'b1111, 1, 32'h12345678};
    vecs[6] = '{1'b1, 1'b1, 32'h44,   32'hAB000000, 4'b1000, 5, 32'h12345678};
    vecs[7] = '{1'b1, 1'b0, 32'h44,   32'h0,        4'b0000, 0, 32'hAB000000};
    exp_ord = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk_reset_outputs("reset");
    chk("reset_stall_fetch", 32'(stall_fetch), 32'h0);
    chk("reset_stall_pipe", 32'(stall_pipe), 32'h0);

    // Single accesses; later ones with spurious mem_ready while idle
    for (int i = 0; i < 8; i++) begin
      wait_cfg    = vecs[i].waits;
      noise_ready = (i >= 4);
      if (vecs[i].is_dm)
        dm_q.push_back('{vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                         2 + vecs[i].waits, vecs[i].exp});
      else
        if_q.push_back('{1'b0, vecs[i].addr, 32'h0, 4'b0000, 2 + vecs[i].waits, vecs[i].exp});
      run_until_idle(40);
      step();
    end
    noise_ready = 1'b0;

    // Simultaneous fetch and load: data first, fetch after the bubble
    wait_cfg = 0;
    order_q.delete();
    if_q.push_back('{1'b0, 32'h104, 32'h0, 4'b0000, 5, 32'h00A00093});
    dm_q.push_back('{1'b0, 32'h2000, 32'h0, 4'b0000, 2, 32'h12345678});
    run_until_idle(40);
    chk("simul_count", 32'(order_q.size()), 32'd2);
    if (order_q.size() == 2) begin
      chk("simul_first_dm", 32'(order_q[0]), 32'h1);
      chk("simul_second_if", 32'(order_q[1]), 32'h0);
    end
    step();

    // Fairness with limit 2: fetch waits behind at most two data grants
    order_q.delete();
    if_q.push_back('{1'b0, 32'h100, 32'h0, 4'b0000, -1, 32'h00000013});
    if_q.push_back('{1'b0, 32'h104, 32'h0, 4'b0000, -1, 32'h00A00093});
    dm_q.push_back('{1'b0, 32'h2000, 32'h0, 4'b0000, -1, 32'h12345678});
    dm_q.push_back('{1'b0, 32'h40,   32'h0, 4'b0000, -1, 32'hFFFFBEEF});
    dm_q.push_back('{1'b0, 32'h2000, 32'h0, 4'b0000, -1, 32'h12345678});
    dm_q.push_back('{1'b0, 32'h44,   32'h0, 4'b0000, -1, 32'hAB000000});
    run_until_idle(80);
    chk("fair_count", 32'(order_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < order_q.size()) chk($sformatf("fair_order_%0d", i), 32'(order_q[i]), 32'(exp_ord[i]));
    step();

    // Reset while a load is waiting, then a late mem_ready
    wait_cfg = 10;
    dm_q.push_back('{1'b0, 32'h2000, 32'h0, 4'b0000, -1, 32'h12345678});
    for (int n = 0; n < 10 && !in_access; n++) step();
    chk("abort_access_started", 32'(in_access), 32'h1);
    step();
    step();
    rst = 1'b1;
    dm_req = 1'b0;
    dm_q.delete();
    sb_dm.delete();
    kind_q.delete();
    in_access = 1'b0;
    step();
    rst = 1'b0;
    chk_reset_outputs("abort");
    step();
    noise_ready = 1'b1;
    step();
    step();
    noise_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("abort_no_dm_done", 32'(dm_done), 32'h0);
      chk("abort_mem_req", 32'(mem_req), 32'h0);
      chk("abort_dm_rdata", dm_rdata, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
